// File: rtl/camera_pkg.sv
// camera_pkg: shared state encoding and default parameters for the camera responder
package camera_pkg;
   typedef enum logic [2:0] {
      S_UNINIT,
      S_INITIALIZING,
      S_IDLE,
      S_CAPTURE,
      S_TRANSMIT
   } cam_state_t;
   localparam int DEF_INIT_CYCLES = 16;
   localparam int DEF_PIXELS      = 8;
   localparam int DEF_PIXEL_W     = 8;
endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: PIXELS x PIXEL_W pixel store, one synchronous write port, one combinational read port
// Ports: clock, we/waddr/wdata (write), raddr -> rdata (read). Storage is not reset.
module frame_buffer
   import camera_pkg::*;
#(
   parameter int PIXELS  = DEF_PIXELS,
   parameter int PIXEL_W = DEF_PIXEL_W,
   parameter int AW      = $clog2(DEF_PIXELS)
) (
   input  logic               clock,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [PIXEL_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [PIXEL_W-1:0] rdata
);
   logic [PIXEL_W-1:0] mem [PIXELS];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/camera_responder.sv
// camera_responder: init/take/send command responder with frame capture and valid/ready streaming
// Ports: clock, reset_n (async active-low); init/take/send strobes -> done_init/done_take/done_send pulses;
//        pixel_in/pixel_valid sensor input; data_out/data_valid/data_ready outgoing stream.
// Optional: CAM_CHECKSUM_EN appends an XOR-of-frame beat after the last pixel.
module camera_responder
   import camera_pkg::*;
#(
   parameter int INIT_CYCLES = DEF_INIT_CYCLES,
   parameter int PIXELS      = DEF_PIXELS,
   parameter int PIXEL_W     = DEF_PIXEL_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               init,
   input  logic               take,
   input  logic               send,
   output logic               done_init,
   output logic               done_take,
   output logic               done_send,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               pixel_valid,
   output logic [PIXEL_W-1:0] data_out,
   output logic               data_valid,
   input  logic               data_ready
);
   localparam int IW = $clog2(PIXELS + 1);
   localparam int AW = $clog2(PIXELS);
   localparam int CW = $clog2(INIT_CYCLES + 1);
`ifdef CAM_CHECKSUM_EN
   localparam int LAST = PIXELS;
`else
   localparam int LAST = PIXELS - 1;
`endif
   cam_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               fv_q, fv_d;
   logic               di_q, di_d, dt_q, dt_d, ds_q, ds_d;
   logic               we;
   logic [PIXEL_W-1:0] rdata;
   frame_buffer #(.PIXELS(PIXELS), .PIXEL_W(PIXEL_W), .AW(AW)) u_buf (
      .clock (clock),
      .we    (we),
      .waddr (idx_q[AW-1:0]),
      .wdata (pixel_in),
      .raddr (idx_q[AW-1:0]),
      .rdata (rdata)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      fv_d    = fv_q;
      di_d    = 1'b0;
      dt_d    = 1'b0;
      ds_d    = 1'b0;
      we      = 1'b0;
      case (state_q)
         S_UNINIT:
            if (init) begin
               state_d = S_INITIALIZING;
               cnt_d   = CW'(INIT_CYCLES - 1);
            end
         S_INITIALIZING:
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               di_d    = 1'b1;
               fv_d    = 1'b0;
            end else cnt_d = cnt_q - CW'(1);
         S_IDLE:
            if (take) begin
               state_d = S_CAPTURE;
               idx_d   = '0;
            end else if (send) begin
               state_d = S_TRANSMIT;
               idx_d   = '0;
            end else if (init) begin
               state_d = S_INITIALIZING;
               cnt_d   = CW'(INIT_CYCLES - 1);
            end
         S_CAPTURE:
            if (pixel_valid) begin
               we = 1'b1;
               if (idx_q == IW'(PIXELS - 1)) begin
                  state_d = S_IDLE;
                  fv_d    = 1'b1;
                  dt_d    = 1'b1;
               end else idx_d = idx_q + IW'(1);
            end
         S_TRANSMIT:
            if (!fv_q) begin
               state_d = S_IDLE;
               ds_d    = 1'b1;
            end else if (data_ready) begin
               if (idx_q == IW'(LAST)) begin
                  state_d = S_IDLE;
                  ds_d    = 1'b1;
               end else idx_d = idx_q + IW'(1);
            end
         default: state_d = S_UNINIT;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= S_UNINIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         fv_q    <= 1'b0;
         di_q    <= 1'b0;
         dt_q    <= 1'b0;
         ds_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         fv_q    <= fv_d;
         di_q    <= di_d;
         dt_q    <= dt_d;
         ds_q    <= ds_d;
      end
   assign done_init  = di_q;
   assign done_take  = dt_q;
   assign done_send  = ds_q;
   assign data_valid = (state_q == S_TRANSMIT) && fv_q;
`ifdef CAM_CHECKSUM_EN
   logic [PIXEL_W-1:0] cks_q, cks_d;
   // running XOR restarts on the first pixel of every capture
   always_comb begin
      cks_d = cks_q;
      if (we) cks_d = (idx_q == '0) ? pixel_in : (cks_q ^ pixel_in);
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cks_q <= '0;
      else cks_q <= cks_d;
   assign data_out = !data_valid ? '0 : (idx_q == IW'(PIXELS)) ? cks_q : rdata;
`else
   assign data_out = data_valid ? rdata : '0;
`endif
endmodule

// File: tb/tb_camera_responder.sv
// tb_camera_responder: directed self-checking bench for camera_responder
module tb_camera_responder;
`ifdef CAM_CHECKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       init = 1'b0, take = 1'b0, send = 1'b0;
   logic       done_init, done_take, done_send;
   logic [7:0] pixel_in = 8'h00;
   logic       pixel_valid = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b0;
   logic [7:0] exp_buf [8];
   int         vectors = 0;
   int         miscompares = 0;

   camera_responder #(.INIT_CYCLES(16), .PIXELS(8), .PIXEL_W(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .init        (init),
      .take        (take),
      .send        (send),
      .done_init   (done_init),
      .done_take   (done_take),
      .done_send   (done_send),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #3;
      vectors++;
      if ({done_init, done_take, done_send, data_valid} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 0000", {done_init, done_take, done_send, data_valid});
      end
      vectors++;
      if (data_out !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data_out got %h want 00", data_out);
      end
      step;
      reset_n = 1'b1;
      take = 1'b1;
      send = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step;
         vectors++;
         if ({done_take, done_send, data_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL uninit_strobes cycle %0d got %b want 000", i, {done_take, done_send, data_valid});
         end
      end
      take = 1'b0;
      send = 1'b0;
   endtask

   // init sampled at edge N; done_init must appear only after edge N+16
   task automatic do_init(input string nm, input bit noise);
      init = 1'b1;
      step;
      init = 1'b0;
      take = noise;
      send = noise;
      for (int j = 1; j <= 16; j++) begin
         step;
         vectors++;
         if ({done_init, done_take, done_send, data_valid} !== {(j == 16), 3'b000}) begin
            miscompares++;
            $display("FAIL %s cycle %0d got %b want %b", nm, j,
                     {done_init, done_take, done_send, data_valid}, {(j == 16), 3'b000});
         end
      end
      take = 1'b0;
      send = 1'b0;
   endtask

   task automatic capture(input logic [7:0] base, input bit onehot, input bit send_noise);
      int k = 0;
      logic v;
      logic [7:0] val;
      take = 1'b1;
      send = send_noise;
      step;
      take = 1'b0;
      for (int i = 0; i < 24 && k < 8; i++) begin
         v = (i % 3) != 1;
         val = onehot ? (8'h01 << k) : base + 8'(k);
         pixel_valid = v;
         pixel_in = v ? val : 8'hEE;
         if (v) exp_buf[k] = val;
         step;
         if (v) k++;
         vectors++;
         if ({done_take, done_send, data_valid} !== {(v && k == 8), 2'b00}) begin
            miscompares++;
            $display("FAIL capture i=%0d got %b want %b", i, {done_take, done_send, data_valid}, {(v && k == 8), 2'b00});
         end
      end
      pixel_valid = 1'b0;
      send = 1'b0;
      vectors++;
      if (k != 8) begin
         miscompares++;
         $display("FAIL capture_bound got %0d pixels want 8", k);
      end
   endtask

   // sends from the current IDLE cycle; returns in the done_send cycle
   task automatic transmit(input string nm, input logic [3:0] pat, output int cycles);
      int b = 0;
      int c = 0;
      logic [7:0] cks = 8'h00;
      logic [7:0] want;
      for (int i = 0; i < 8; i++) cks ^= exp_buf[i];
      send = 1'b1;
      step;
      send = 1'b0;
      while (b < NB && c < 64) begin
         data_ready = pat[c % 4];
         want = (b < 8) ? exp_buf[b] : cks;
         vectors++;
         if (data_valid !== 1'b1 || data_out !== want || done_send !== 1'b0) begin
            miscompares++;
            $display("FAIL %s beat %0d got v=%b d=%h ds=%b want v=1 d=%h ds=0", nm, b, data_valid, data_out, done_send, want);
         end
         if (data_ready) b++;
         step;
         c++;
      end
      data_ready = 1'b0;
      cycles = c;
      vectors++;
      if (done_send !== 1'b1 || data_valid !== 1'b0 || b != NB) begin
         miscompares++;
         $display("FAIL %s_done got ds=%b v=%b beats=%0d want ds=1 v=0 beats=%0d", nm, done_send, data_valid, b, NB);
      end
   endtask

   task automatic test_send;
      int c;
      transmit("send_stall", 4'b1001, c);
   endtask

   task automatic test_back_to_back;
      int c;
      for (int r = 0; r < 2; r++) begin
         transmit("resend", 4'b1111, c);
         vectors++;
         if (c != NB) begin
            miscompares++;
            $display("FAIL resend_cycles got %0d want %0d", c, NB);
         end
      end
   endtask

   task automatic test_send_empty;
      int pulses = 0;
      do_init("reinit", 1'b0);
      send = 1'b1;
      step;
      send = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_valid cycle %0d got %b want 0", i, data_valid);
         end
         step;
         if (done_send === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL empty_done_pulses got %0d want 1", pulses);
      end
   endtask

   task automatic test_reset_mid_transmit;
      send = 1'b1;
      step;
      send = 1'b0;
      data_ready = 1'b0;
      step;
      vectors++;
      if (data_valid !== 1'b1 || data_out !== exp_buf[0]) begin
         miscompares++;
         $display("FAIL pre_abort got v=%b d=%h want v=1 d=%h", data_valid, data_out, exp_buf[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (data_valid !== 1'b0 || data_out !== 8'h00) begin
         miscompares++;
         $display("FAIL abort got v=%b d=%h want v=0 d=00", data_valid, data_out);
      end
      step;
      reset_n = 1'b1;
      send = 1'b1;
      step;
      send = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         vectors++;
         if ({done_send, data_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_uninit cycle %0d got %b want 00", i, {done_send, data_valid});
         end
      end
   endtask

   initial begin
      test_reset;
      do_init("init_latency", 1'b1);
      capture(8'h10, 1'b0, 1'b0);
      test_send;
      test_back_to_back;
      test_send_empty;
      capture(8'hA0, 1'b0, 1'b1);
      test_reset_mid_transmit;
      do_init("init_after_abort", 1'b0);
      capture(8'h00, 1'b1, 1'b0);
      test_send;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
